// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: digit sequencing with blanking guard,
// zero/mask suppression and frame-aligned display updates over valid/ready.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_en,
    input  logic        lz_en,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_digits,
    input  logic [7:0]  upd_dp,
    input  logic [7:0]  upd_mask,
    output logic [2:0]  dig_sel,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_tick
);

    localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int unsigned DIV_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [DIV_W-1:0] BLANK_LAST   = DIV_W'(BLANK_CYC - 1);
    localparam logic [DIV_W-1:0] REFRESH_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       DIG_LAST     = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_DRIVE} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       dig_q, dig_d;
    // Masks are held inverted (1 = dark) so the cleared register shows every digit.
    logic [31:0]      nib_q, nib_d, pnib_q, pnib_d;
    logic [7:0]       dpv_q, dpv_d, pdpv_q, pdpv_d;
    logic [7:0]       off_q, off_d, poff_q, poff_d;
    logic             pend_q, pend_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             ft_q, ft_d;
    logic             rdy_q, rdy_d;
    logic             frame_wrap;
    logic             dark_now;
    logic [3:0]       cur_nib;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            4'hF: return 7'h0E;
        endcase
    endfunction

    // Dark when masked off, or a leading zero (digit 0 always shown).
    function automatic logic digit_dark(input logic [2:0] idx, input logic [31:0] nibs,
                                        input logic [7:0] off, input logic lz);
        logic hi_zero;
        hi_zero = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < NUM_DIGITS && i >= 32'(idx) && nibs[4*i +: 4] != 4'h0) hi_zero = 1'b0;
        end
        return off[idx] | (lz & (idx != 3'd0) & hi_zero);
    endfunction

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        dig_d      = dig_q;
        nib_d      = nib_q;
        dpv_d      = dpv_q;
        off_d      = off_q;
        pnib_d     = pnib_q;
        pdpv_d     = pdpv_q;
        poff_d     = poff_q;
        pend_d     = pend_q;
        frame_wrap = 1'b0;
        an_d       = 8'hFF;
        seg_d      = 7'h7F;
        dp_d       = 1'b1;

        case (state_q)
            ST_OFF: begin
                state_d = ST_BLANK;
                div_d   = '0;
                dig_d   = 3'd0;
            end
            ST_BLANK: begin
                if (div_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (div_q == REFRESH_LAST) begin
                    state_d = ST_BLANK;
                    div_d   = '0;
                    if (dig_q == DIG_LAST) begin
                        dig_d      = 3'd0;
                        frame_wrap = 1'b1;
                    end else begin
                        dig_d = dig_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase

        if (!disp_en) begin
            state_d    = ST_OFF;
            div_d      = '0;
            dig_d      = 3'd0;
            frame_wrap = 1'b0;
        end

        // Pending word lands only on a frame boundary (or immediately while dark).
        if (pend_q && (frame_wrap || state_q == ST_OFF)) begin
            nib_d  = pnib_q;
            dpv_d  = pdpv_q;
            off_d  = poff_q;
            pend_d = 1'b0;
        end else if (upd_valid && rdy_q) begin
            pnib_d = upd_digits;
            pdpv_d = upd_dp;
            poff_d = ~upd_mask;
            pend_d = 1'b1;
        end

        cur_nib  = nib_d[{dig_d, 2'b00} +: 4];
        dark_now = digit_dark(dig_d, nib_d, off_d, lz_en);
        if (state_d != ST_OFF) begin
            seg_d = seg_decode(cur_nib);
            dp_d  = ~(dpv_d[dig_d] & ~dark_now);
            if (state_d == ST_DRIVE && !dark_now) an_d = ~(8'd1 << dig_d);
        end
        ft_d  = frame_wrap;
        rdy_d = ~pend_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            div_q   <= '0;
            dig_q   <= 3'd0;
            nib_q   <= '0;
            dpv_q   <= '0;
            off_q   <= '0;
            pnib_q  <= '0;
            pdpv_q  <= '0;
            poff_q  <= '0;
            pend_q  <= 1'b0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            ft_q    <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            dig_q   <= dig_d;
            nib_q   <= nib_d;
            dpv_q   <= dpv_d;
            off_q   <= off_d;
            pnib_q  <= pnib_d;
            pdpv_q  <= pdpv_d;
            poff_q  <= poff_d;
            pend_q  <= pend_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            ft_q    <= ft_d;
            rdy_q   <= rdy_d;
        end
    end

    assign dig_sel    = dig_q;
    assign an_n       = an_q;
    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign frame_tick = ft_q;
    assign upd_ready  = rdy_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic against a
// frame-position reference model.
module tb_seg_scan_ctrl;

    localparam int unsigned N     = 4;
    localparam int unsigned R     = 4;
    localparam int unsigned B     = 1;
    localparam int unsigned PER   = B + R;
    localparam int unsigned FRAME = N * PER;
    localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst_n, disp_en, lz_en, upd_valid, upd_ready;
    logic [31:0] upd_digits;
    logic [7:0]  upd_dp, upd_mask;
    logic [2:0]  dig_sel;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n, frame_tick;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYC(B)) dut (
        .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .lz_en(lz_en),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_digits(upd_digits),
        .upd_dp(upd_dp), .upd_mask(upd_mask), .dig_sel(dig_sel), .an_n(an_n),
        .seg_n(seg_n), .dp_n(dp_n), .frame_tick(frame_tick)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: on/off plus position within the frame; digit = pos/PER,
    // first B cycles of each digit slot are the blanking guard.
    logic        m_on, m_pend, m_ft, m_acc;
    int          m_pos;
    logic [31:0] m_dig, p_dig;
    logic [7:0]  m_dpv, m_msk, p_dpv, p_msk;

    function automatic logic m_dark(input int i);
        if (!m_msk[i]) return 1'b1;
        if (lz_en && i > 0) begin
            for (int j = i; j < N; j++) if (m_dig[4*j +: 4] != 4'h0) return 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        logic wrap, was_off;
        m_acc = 1'b0;
        if (!rst_n) begin
            m_on = 0; m_pos = 0; m_pend = 0; m_ft = 0;
            m_dig = '0; m_dpv = '0; m_msk = '1;
            p_dig = '0; p_dpv = '0; p_msk = '1;
            return;
        end
        wrap    = m_on && disp_en && (m_pos == FRAME - 1);
        was_off = !m_on;
        if (!disp_en) begin
            m_on = 0; m_pos = 0;
        end else if (!m_on) begin
            m_on = 1; m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
        end
        if (m_pend && (wrap || was_off)) begin
            m_dig = p_dig; m_dpv = p_dpv; m_msk = p_msk; m_pend = 0;
        end else if (upd_valid && !m_pend) begin
            p_dig = upd_digits; p_dpv = upd_dp; p_msk = upd_mask; m_pend = 1; m_acc = 1;
        end
        m_ft = wrap;
    endtask

    task automatic check_outputs();
        int d;
        logic drive, dk;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        logic [2:0] e_sel;
        if (!m_on) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_sel = 3'd0;
        end else begin
            d     = m_pos / PER;
            drive = (m_pos % PER) >= B;
            dk    = m_dark(d);
            e_sel = 3'(d);
            e_seg = SEG_TBL[m_dig[4*d +: 4]];
            e_dp  = !(m_dpv[d] && !dk);
            e_an  = (drive && !dk) ? ~(8'd1 << d) : 8'hFF;
        end
        check_eq("dig_sel", 32'(dig_sel), 32'(e_sel));
        check_eq("an_n", 32'(an_n), 32'(e_an));
        check_eq("seg_n", 32'(seg_n), 32'(e_seg));
        check_eq("dp_n", 32'(dp_n), 32'(e_dp));
        check_eq("frame_tick", 32'(frame_tick), 32'(m_ft));
        check_eq("upd_ready", 32'(upd_ready), 32'(!m_pend));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send_update(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] m);
        upd_digits = d; upd_dp = dp; upd_mask = m; upd_valid = 1'b1;
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick();
            if (m_acc) break;
        end
        check_eq("upd_accept", 32'(m_acc), 32'd1);
        upd_valid = 1'b0;
    endtask

    task automatic wait_slot(input int dg, input int ph);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (m_on && m_pos == dg * PER + ph) break;
            tick();
        end
        check_eq("wait_slot", 32'(m_on && m_pos == dg * PER + ph), 32'd1);
    endtask

    initial begin
        rst_n = 0; disp_en = 0; lz_en = 0; upd_valid = 0;
        upd_digits = '0; upd_dp = '0; upd_mask = '0;
        run(2);
        rst_n = 1;
        run(2);

        // Plain scan of an all-zero word.
        disp_en = 1;
        run(2 * FRAME + 3);

        // Mid-frame update: held off until the wrap.
        wait_slot(1, 2);
        send_update(32'h0000_1234, 8'h02, 8'h0F);
        run(2 * FRAME);

        // Leading-zero suppression.
        lz_en = 1;
        send_update(32'h0000_0050, 8'h00, 8'h0F);
        run(2 * FRAME);

        // Second request held while the first is pending.
        wait_slot(2, 1);
        send_update(32'h0000_9A0F, 8'h0C, 8'h0B);
        send_update(32'h0000_CDE8, 8'h05, 8'h0F);
        run(2 * FRAME);

        // Display disable during digit 2 and restart.
        lz_en = 0;
        wait_slot(2, 2);
        disp_en = 0;
        run(3);
        disp_en = 1;
        run(FRAME + 2);

        // Reset mid-drive with an update pending.
        wait_slot(0, 3);
        send_update(32'h0000_7777, 8'hFF, 8'h0F);
        wait_slot(1, 2);
        rst_n = 0;
        tick();
        rst_n = 1;
        run(FRAME + 3);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            disp_en = ($urandom % 60) != 0;
            rst_n   = ($urandom % 700) != 0;
            if ($urandom % 80 == 0) lz_en = ~lz_en;
            if (upd_valid && m_acc) upd_valid = 1'b0;
            if (!upd_valid && ($urandom % 10 == 0)) begin
                upd_valid  = 1'b1;
                upd_digits = ($urandom % 3 == 0) ? ($urandom & 32'h0000_0F0F) : $urandom;
                upd_dp     = 8'($urandom);
                upd_mask   = ($urandom % 2 == 0) ? 8'hFF : 8'($urandom);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the stopwatch's 7-segment display bank.
- Sequences the digit index that drives dec_3_8 (`dig_sel`) and emits the matching gated active-low anode vector, segments and decimal point.
- Inserts a blanking guard between digits to prevent ghosting.
- Accepts new display words through a valid/ready handshake and applies them only at frame boundaries, so no frame shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 8, digits scanned (1..8); digit index wraps at NUM_DIGITS-1.
- REFRESH_DIV, 50000, clk cycles each digit is driven (>=1).
- BLANK_CYC, 500, clk cycles with all anodes off between digits (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- disp_en  in  1  1 = scanning; 0 = display dark.
- lz_en  in  1  1 = suppress leading zeros.
- upd_valid  in  1  update request.
- upd_ready  out  1  controller can accept an update.
- upd_digits  in  32  8 x 4-bit hex nibbles; nibble i = digit i; digit 0 is least significant.
- upd_dp  in  8  decimal point per digit, 1 = lit.
- upd_mask  in  8  digit enable per digit, 0 = digit always dark.
- dig_sel  out  3  current digit index, to dec_3_8.
- an_n  out  8  gated active-low anodes: ~(1<<dig_sel) while driving, else 8'hFF.
- seg_n  out  7  active-low segments, bit order gfedcba.
- dp_n  out  1  active-low decimal point.
- frame_tick  out  1  one-cycle pulse on frame wrap.

Behaviour:
- Reset (rst_n=0 at clk edge) puts the block in the following state:
  - state OFF, divider 0, dig_sel 0.
  - an_n 8'hFF, seg_n 7'h7F, dp_n 1, frame_tick 0, upd_ready 1.
  - active and pending display registers all 0, pending flag 0.
  - Reset mid-scan aborts immediately and drops any pending update.
- All outputs are registered.
- FSM states are OFF, BLANK and DRIVE:
  - OFF: outputs dark. When disp_en=1, go to BLANK with dig_sel=0 and divider=0.
  - BLANK: an_n=8'hFF. seg_n and dp_n already show the current digit. After BLANK_CYC cycles, go to DRIVE and reset the divider.
  - DRIVE: an_n=~(1<<dig_sel) unless the digit is suppressed, in which case an_n=8'hFF. After REFRESH_DIV cycles, go to BLANK and advance dig_sel.
  - Advancing from dig_sel=NUM_DIGITS-1 wraps to 0 and asserts frame_tick on that same cycle (the DRIVE->BLANK edge).
  - disp_en=0 in any state: OFF on the next cycle, outputs dark, divider cleared. Re-enabling always restarts at digit 0.
- Per-digit timing: BLANK_CYC+REFRESH_DIV cycles. Frame: NUM_DIGITS*(BLANK_CYC+REFRESH_DIV) cycles.
- Suppression: a digit is dark when upd_mask[i]=0.
  - With lz_en=1, digit i>=1 is also dark when nibble i and every higher nibble (up to NUM_DIGITS-1) are 0.
  - Digit 0 is never zero-suppressed.
  - dp_n for a dark digit is 1.
- Segment decode (seg_n, hex for 0..F): 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Update handshake:
  - An update transfers when upd_valid && upd_ready; it is captured into the pending registers and the pending flag is set.
  - upd_ready equals !pending.
  - Pending contents copy to the active registers on the frame-wrap cycle, or on the next cycle if the state is OFF.
  - The pending flag clears at the same time, so upd_ready returns 1 on the following cycle.
  - An update accepted on the very frame-wrap cycle is not applied at that wrap; it applies at the next wrap.
  - upd_valid while upd_ready=0 is ignored; the source must hold it.
- Digits >= NUM_DIGITS in upd_* are stored but never displayed.

Test Plan:
- Use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1 for all scenarios.
1. Reset then disp_en=1 with no update. Required:
   - an_n=FF for 1 cycle, then FE for 4 cycles, then FF for 1, then FD for 4, then FB, then F7.
   - frame_tick pulses once every 20 cycles.
   - seg_n=40 throughout.
2. Update digits=0x1234, mask=0F, dp=02, mid-frame. Required:
   - upd_ready drops the cycle after acceptance.
   - Old digits remain visible until the wrap.
   - After the wrap: digit0 seg 19, digit1 seg 30 with dp_n=0, digit2 24, digit3 79.
   - upd_ready returns to 1.
3. lz_en=1, digits=0x0050. Required:
   - Digits 3 and 2 keep an_n=FF during DRIVE.
   - Digit 1 shows 12; digit 0 shows 40.
4. Second upd_valid held while pending. Required:
   - Not accepted until the cycle after the wrap.
   - Applied at the following wrap.
5. disp_en dropped during DRIVE of digit 2. Required:
   - Next cycle an_n=FF, seg_n=7F, dp_n=1.
   - On re-enable, the scan restarts at dig_sel=0.
6. rst_n pulsed low for 1 cycle mid-DRIVE with an update pending. Required:
   - All outputs return to their reset values.
   - The pending update is discarded and upd_ready=1.
